// File: rtl/uart_frame_bridge.sv
// uart_frame_bridge: UART byte stream to frame queue, plus result word back to UART bytes; FRAME_TIMEOUT_EN adds an inter-byte idle timeout
module uart_frame_bridge #(
  parameter int DBITS = 8,
  parameter int FRAME_BYTES = 8,
  parameter int DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx_valid,
  input  logic [DBITS-1:0]             rx_byte,
  output logic                         out_valid,
  output logic [FRAME_BYTES*DBITS-1:0] out_data,
  input  logic                         out_ready,
  input  logic                         res_valid,
  input  logic [FRAME_BYTES*DBITS-1:0] res_value,
  input  logic                         output_en,
  output logic                         tx_valid,
  output logic [DBITS-1:0]             tx_byte,
  input  logic                         tx_ready,
  output logic                         tx_busy,
  output logic                         partial,
  output logic [7:0]                   frames_dropped
);
  localparam int W = FRAME_BYTES * DBITS;
  localparam int BW = FRAME_BYTES > 1 ? $clog2(FRAME_BYTES) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [BW-1:0] LAST = BW'(FRAME_BYTES - 1);
  typedef enum logic {IDLE, SEND} state_t;
  logic [BW-1:0] cnt;
  logic [W-1:0] asm_q;
  logic [W-1:0] frame;
  logic push, pop, full, wr_en, drop, tmo;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] fill;
  state_t state, state_n;
  logic [W-1:0] sh;
  logic [BW-1:0] idx;
  logic en_q, start, adv;
  assign frame = {asm_q[W-DBITS-1:0], rx_byte};
  assign push = rx_valid && cnt == LAST;
  assign partial = cnt != '0;
`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle;
  assign tmo = partial && !rx_valid && idle == TW'(TIMEOUT_CYCLES - 1);
  // idle counter runs only while a partial frame waits for its next byte
  always_ff @(posedge clk or posedge reset)
    if (reset) idle <= '0;
    else if (rx_valid || !partial || tmo) idle <= '0;
    else idle <= idle + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  // shift bytes in MSB-first; byte count wraps on the last byte of a frame
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      asm_q <= '0;
    end else if (rx_valid) begin
      asm_q <= frame;
      cnt <= push ? '0 : cnt + 1'b1;
    end else if (tmo) cnt <= '0;
  assign full = fill == (AW+1)'(DEPTH);
  assign out_valid = fill != '0;
  assign out_data = mem[rd];
  assign pop = out_valid && out_ready;
  assign wr_en = push && (!full || pop);
  assign drop = push && full && !pop;
  // frame FIFO; a full queue still accepts a push when the head leaves the same cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd <= '0;
      wr <= '0;
      fill <= '0;
      frames_dropped <= '0;
    end else begin
      if (wr_en) begin
        mem[wr] <= frame;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      fill <= fill + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
      if (drop && frames_dropped != 8'hFF) frames_dropped <= frames_dropped + 1'b1;
    end
  // next state: a send starts on an output_en rising edge with a valid result
  always_comb begin
    start = 1'b0;
    adv = 1'b0;
    state_n = state;
    start = state == IDLE && output_en && !en_q && res_valid;
    adv = state == SEND && tx_ready;
    state_n = start ? SEND : (adv && idx == LAST) ? IDLE : state;
  end
  // TX state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // result shift register drains MSB-first, one byte per handshake
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      en_q <= 1'b0;
      sh <= '0;
      idx <= '0;
    end else begin
      en_q <= output_en;
      if (start) begin
        sh <= res_value;
        idx <= '0;
      end else if (adv) begin
        sh <= {sh[W-DBITS-1:0], {DBITS{1'b0}}};
        idx <= idx + 1'b1;
      end
    end
  assign tx_valid = state == SEND;
  assign tx_busy = state == SEND;
  assign tx_byte = sh[W-1 -: DBITS];
endmodule

// File: tb/tb_uart_frame_bridge.sv
// tb_uart_frame_bridge: directed checks of frame assembly, queueing, drops, result send and reset
module tb_uart_frame_bridge;
  logic clk = 1'b0;
  logic reset, rx_valid, out_valid, out_ready, res_valid, output_en;
  logic tx_valid, tx_ready, tx_busy, partial;
  logic [7:0] rx_byte, tx_byte, frames_dropped;
  logic [63:0] out_data, res_value, txe;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  uart_frame_bridge #(.DBITS(8), .FRAME_BYTES(8), .DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .res_valid(res_valid), .res_value(res_value), .output_en(output_en),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .partial(partial), .frames_dropped(frames_dropped)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte = b;
    step();
    rx_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < 8; i++) send(8'(base + i));
  endtask
  function automatic logic [63:0] fr(input logic [7:0] base);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[55:0], 8'(base + i)};
    return r;
  endfunction
  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_byte = '0; out_ready = 1'b0;
    res_valid = 1'b0; res_value = '0; output_en = 1'b0; tx_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_partial", partial, 0);
    chk("rst_dropped", frames_dropped, 0);
    reset = 1'b0;
    step();
    for (int i = 1; i <= 7; i++) send(8'(i));
    chk("asm_partial7", partial, 1);
    chk("asm_not_valid7", out_valid, 0);
    send(8'h08);
    chk("asm_valid", out_valid, 1);
    chk("asm_data", out_data, 64'h0102030405060708);
    chk("asm_partial0", partial, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop_empty", out_valid, 0);
    for (int f = 1; f <= 5; f++) send_frame(8'(8'h10 * f));
    chk("full_dropped", frames_dropped, 1);
    chk("full_head", out_data, 64'h1011121314151617);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, fr(8'(8'h10 * k)));
      step();
    end
    chk("drain_empty", out_valid, 0);
    out_ready = 1'b0;
    for (int f = 6; f <= 9; f++) send_frame(8'(8'h10 * f));
    for (int i = 0; i < 7; i++) send(8'(8'hA0 + i));
    out_ready = 1'b1;
    send(8'hA7);
    chk("pushpop_dropped", frames_dropped, 1);
    chk("pushpop_head", out_data, 64'h7071727374757677);
    for (int k = 7; k <= 10; k++) begin
      chk("pushpop_data", out_data, fr(8'(8'h10 * k)));
      step();
    end
    chk("pushpop_empty", out_valid, 0);
    out_ready = 1'b0;
    for (int f = 0; f < 258; f++) send_frame(8'h00);
    chk("sat_reach", frames_dropped, 255);
    send_frame(8'h00);
    chk("sat_hold", frames_dropped, 255);
    out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;
    chk("sat_drained", out_valid, 0);
    txe = 64'hDEADBEEF00C0FFEE;
    res_value = txe;
    res_valid = 1'b1;
    output_en = 1'b1;
    step();
    output_en = 1'b0;
    chk("tx_start_valid", tx_valid, 1);
    chk("tx_start_busy", tx_busy, 1);
    chk("tx_start_byte", tx_byte, 64'hDE);
    for (int i = 0; i < 8; i++) begin
      tx_ready = 1'b0;
      if (i == 3) begin
        output_en = 1'b1;
        res_value = 64'h1111111111111111;
      end
      if (i == 4) output_en = 1'b0;
      step();
      chk("tx_hold_byte", tx_byte, txe[63-8*i -: 8]);
      chk("tx_hold_valid", tx_valid, 1);
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      if (i < 7) chk("tx_next_byte", tx_byte, txe[55-8*i -: 8]);
      else begin
        chk("tx_done_busy", tx_busy, 0);
        chk("tx_done_valid", tx_valid, 0);
      end
    end
    res_valid = 1'b0;
    output_en = 1'b0;
    step();
    output_en = 1'b1;
    step();
    output_en = 1'b0;
    chk("tx_no_result", tx_busy, 0);
    send(8'hA1);
    send(8'hA2);
    send(8'hA3);
    chk("tmo_partial", partial, 1);
    repeat (16) step();
`ifdef FRAME_TIMEOUT_EN
    chk("tmo_cleared", partial, 0);
`else
    chk("tmo_held", partial, 1);
`endif
    send_frame(8'h11);
    chk("tmo_valid", out_valid, 1);
`ifdef FRAME_TIMEOUT_EN
    chk("tmo_frame", out_data, 64'h1112131415161718);
    chk("tmo_partial_end", partial, 0);
`else
    chk("stale_frame", out_data, 64'hA1A2A31112131415);
    chk("stale_partial_end", partial, 1);
`endif
    send(8'h55);
    send(8'h66);
    res_value = 64'h0123456789ABCDEF;
    res_valid = 1'b1;
    output_en = 1'b1;
    step();
    output_en = 1'b0;
    chk("pre_rst_busy", tx_busy, 1);
    chk("pre_rst_partial", partial, 1);
    chk("pre_rst_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_tx_byte", tx_byte, 0);
    chk("arst_tx_busy", tx_busy, 0);
    chk("arst_partial", partial, 0);
    chk("arst_dropped", frames_dropped, 0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_empty", out_valid, 0);
    chk("post_rst_idle", tx_busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
